frame_capture: RTL
==================

# frame_capture

Parametrised successor of the CAN frame storage stage. Accumulates destuffed bus bits at each sample point into a working shift register and counts them. On an end-of-frame strobe from the decoder, it commits the captured bits, bit count and overflow status into an output holding register with a valid/ready handshake. Sits between the bit-timing/destuff logic and the frame decoder/CRC checker.

## Interface
- FRAME_W, default 590: capacity in bits of the working and output registers (≥2).
- LEN_W, default $clog2(FRAME_W+1): width of the bit-count fields.
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- sample_point  in  1  one-cycle strobe; the bus bit is valid this cycle.
- can_rx  in  1  sampled bus level; 1 = recessive.
- is_stuff  in  1  qualifies sample_point; 1 = the current bit is a stuff bit and is discarded.
- frame_end  in  1  one-cycle strobe; commit the current frame.
- frame_abort  in  1  one-cycle strobe; discard the current frame (error frame / bus error).
- out_ready  in  1  consumer accepts the held frame.
- out_valid  out  1  held frame is available.
- out_frame  out  FRAME_W  held bits, right-aligned; most recent bit at bit 0.
- out_len  out  LEN_W  number of valid bits in out_frame.
- out_overflow  out  1  held frame exceeded FRAME_W bits.
- dropped  out  1  one-cycle pulse; a committed frame was lost.

## Operation
- Working state: work[FRAME_W-1:0], cnt[LEN_W-1:0], ovf.
- Store: sample_point && !is_stuff && cnt < FRAME_W → work <= {work[FRAME_W-2:0], can_rx}; cnt <= cnt+1.
- Saturation: sample_point && !is_stuff && cnt == FRAME_W → work and cnt unchanged, ovf <= 1 (sticky until commit/abort).
- is_stuff with sample_point: no change to any state. is_stuff without sample_point: ignored.
- Commit (frame_end && !frame_abort):
  - The effective frame includes any bit stored in the same cycle.
  - If out_valid && !out_ready: output unchanged; dropped pulses for 1 cycle.
  - Otherwise: out_frame/out_len/out_overflow load the effective frame, and out_valid <= 1.
  - In both cases work, cnt and ovf clear.
- Abort: frame_abort → work, cnt and ovf clear. This happens regardless of frame_end or sample_point in the same cycle. Abort wins over commit; the output register is untouched.
- Handshake: out_valid && out_ready with no commit → out_valid <= 0.
  - Output data holds its value until the next load.
  - While out_valid && !out_ready, all out_* fields are stable.
- Zero-length commit (cnt == 0): legal. Loads out_len = 0, out_frame = 0, out_valid = 1.
- Bits beyond cnt in out_frame are 0, because work clears on commit/abort.

## Timing
- Reset values: out_valid = 0, out_frame = 0, out_len = 0, out_overflow = 0, dropped = 0; work = 0, cnt = 0, ovf = 0.
- Reset dominates every other input in the same cycle.
- A bit sampled at edge N is visible in work after edge N.
- A commit at edge N sets out_valid after edge N (1-cycle latency from frame_end).
- A transfer completes on any edge with out_valid && out_ready.
- out_ready is ignored while out_valid = 0.
- Back-to-back: commit in the same cycle as a transfer of the previous frame is accepted (no drop). Throughput is one frame per cycle.
- Reset mid-frame: the partial frame is lost silently; no dropped pulse.

## Structure
- Shared package can_pkg: the CAN_MAX_FRAME_BITS = 590 constant, used as the default for FRAME_W.
- LEN_W is derived locally.
- One natural sub-module: frame_hold_reg, the output holding register with its valid/ready handshake and drop detection.
- The bit accumulator (work/cnt/ovf) stays in the top module.

## Test plan
- Basic shift, FRAME_W=8:
  - Stimulus: bits 1,1,0,(1 stuff),0,1 with sample_point, then frame_end; out_ready=0.
  - Response: out_frame = 8'b0001_1001, out_len = 5, out_overflow = 0, out_valid = 1.
- Abort and reset:
  - Stimulus: 3 bits then frame_abort; then 2 bits of 1 and frame_end.
  - Response: out_frame = 8'b0000_0011, out_len = 2.
  - Also: reset mid-frame → all outputs 0, and a subsequent frame starts from an empty register.
- Overflow, FRAME_W=8:
  - Stimulus: 10 bits alternating 1,0 from a 1, then frame_end.
  - Response: out_len = 8, out_overflow = 1, out_frame = 8'b1010_1010 (first 8 bits kept).
  - The next frame reports out_overflow = 0.
- Drop:
  - Stimulus: hold out_ready = 0; commit frame A (len 3); commit frame B.
  - Response: dropped pulses exactly 1 cycle; output still shows A.
  - Raising out_ready → out_valid falls the next cycle.
- Simultaneous events:
  - sample_point + frame_end same cycle → the bit is included (out_len counts it).
  - frame_end + frame_abort → no load, no dropped pulse.
  - commit + out_ready with out_valid = 1 → the new frame is loaded, out_valid stays 1, no drop.
- Zero-length commit:
  - Stimulus: frame_end with no bits stored.
  - Response: out_valid = 1, out_len = 0, out_frame = 0.

Source files
------------

// File: rtl/can_pkg.sv
// can_pkg: shared CAN constants.
package can_pkg;
  localparam int CAN_MAX_FRAME_BITS = 590;
endpackage

// File: rtl/frame_hold_reg.sv
// frame_hold_reg: output holding register with valid/ready handshake and drop detection.
module frame_hold_reg #(
  parameter int FRAME_W = 590,
  parameter int LEN_W = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [FRAME_W-1:0] frame,
  input  logic [LEN_W-1:0]   len,
  input  logic               ovf,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [FRAME_W-1:0] out_frame,
  output logic [LEN_W-1:0]   out_len,
  output logic               out_overflow,
  output logic               dropped
);
  logic blocked;
  assign blocked = out_valid && !out_ready;
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_frame <= '0;
      out_len <= '0;
      out_overflow <= 1'b0;
      dropped <= 1'b0;
    end else begin
      dropped <= load && blocked;
      if (load && !blocked) begin
        out_valid <= 1'b1;
        out_frame <= frame;
        out_len <= len;
        out_overflow <= ovf;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/frame_capture.sv
// frame_capture: accumulates destuffed CAN bits and commits whole frames to a held output.
module frame_capture
  import can_pkg::*;
#(
  parameter int FRAME_W = CAN_MAX_FRAME_BITS,
  parameter int LEN_W = $clog2(FRAME_W + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sample_point,
  input  logic               can_rx,
  input  logic               is_stuff,
  input  logic               frame_end,
  input  logic               frame_abort,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [FRAME_W-1:0] out_frame,
  output logic [LEN_W-1:0]   out_len,
  output logic               out_overflow,
  output logic               dropped
);
  logic [FRAME_W-1:0] work, eff_work;
  logic [LEN_W-1:0] cnt, eff_cnt;
  logic ovf, eff_ovf, data_bit, full, store;
  assign data_bit = sample_point && !is_stuff;
  assign full = cnt == LEN_W'(FRAME_W);
  assign store = data_bit && !full;
  // effective frame includes a bit stored in the same cycle as the commit
  always_comb begin
    eff_work = store ? {work[FRAME_W-2:0], can_rx} : work;
    eff_cnt = store ? cnt + 1'b1 : cnt;
    eff_ovf = ovf || (data_bit && full);
  end
  always_ff @(posedge clock) begin
    if (reset || frame_abort || frame_end) begin
      work <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      work <= eff_work;
      cnt <= eff_cnt;
      ovf <= eff_ovf;
    end
  end
  frame_hold_reg #(.FRAME_W(FRAME_W), .LEN_W(LEN_W)) u_hold (
    .clock(clock),
    .reset(reset),
    .load(frame_end && !frame_abort),
    .frame(eff_work),
    .len(eff_cnt),
    .ovf(eff_ovf),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_frame(out_frame),
    .out_len(out_len),
    .out_overflow(out_overflow),
    .dropped(dropped)
  );
endmodule
